sram_arbiter: RTL

Two-port arbiter and timing controller between the 8088 system core and the single external 8-bit asynchronous SRAM. It multiplexes CPU read/write requests and video-fetch read requests onto one shared SRAM address/data/WE pin set, generates registered pin timing, and returns read data with a one-cycle acknowledge. It replaces the direct CPU-to-SRAM hookup at the top level. The only tri-state control is `oSramDataOe`, which the top level uses to drive the `ioSramData` pad.

---
 rtl/sram_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Video/CPU arbiter and pin timing controller for the shared 8-bit async SRAM.
// Optional macro SRAM_ARB_FAIR_EN: alternate grants when both ports contend.
module sram_arbiter #(
  parameter int WAIT = 1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCpuReq,
  input  logic        iCpuWe,
  input  logic [19:0] iCpuAddr,
  input  logic [7:0]  iCpuDataW,
  output logic        oCpuAck,
  output logic [7:0]  oCpuDataR,
  input  logic        iVidReq,
  input  logic [19:0] iVidAddr,
  output logic        oVidAck,
  output logic [7:0]  oVidDataR,
  output logic [19:0] oSramAddr,
  output logic [7:0]  oSramDataW,
  output logic        oSramDataOe,
  output logic        oSramWe,
  input  logic [7:0]  iSramDataR
);

  if (WAIT < 0 || WAIT > 15) begin : g_wait_range
    $error("sram_arbiter: WAIT must be within 0..15");
  end

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        grant_vid_r, grant_vid_s;
  logic        write_r, write_s;
  logic [19:0] addr_r, addr_s;
  logic [7:0]  dataw_r, dataw_s;
  logic        oe_r, oe_s;
  logic        we_r, we_s;
  logic        cpu_ack_r, cpu_ack_s;
  logic        vid_ack_r, vid_ack_s;
  logic [7:0]  cpu_data_r, cpu_data_s;
  logic [7:0]  vid_data_r, vid_data_s;
  logic        pick_vid_s;

`ifdef SRAM_ARB_FAIR_EN
  logic last_vid_r, last_vid_s;

  // Video normally wins; after a video grant a waiting CPU gets the next slot
  always_comb begin
    pick_vid_s = iVidReq && !(iCpuReq && last_vid_r);
    if ((state_r == IDLE) && (iVidReq || iCpuReq)) begin
      last_vid_s = pick_vid_s;
    end else begin
      last_vid_s = last_vid_r;
    end
  end

  // Fairness history flag
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      last_vid_r <= 1'b0;
    end else begin
      last_vid_r <= last_vid_s;
    end
  end
`else
  // Strict video priority
  always_comb begin
    pick_vid_s = iVidReq;
  end
`endif

  // Next-state and next-pin computation
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    grant_vid_s = grant_vid_r;
    write_s     = write_r;
    addr_s      = addr_r;
    dataw_s     = dataw_r;
    oe_s        = oe_r;
    we_s        = we_r;
    cpu_ack_s   = 1'b0;
    vid_ack_s   = 1'b0;
    cpu_data_s  = cpu_data_r;
    vid_data_s  = vid_data_r;

    case (state_r)
      IDLE: begin
        if (iVidReq || iCpuReq) begin
          state_s     = ACCESS;
          cnt_s       = WAIT_CNT;
          grant_vid_s = pick_vid_s;
          if (pick_vid_s) begin
            addr_s  = iVidAddr;
            write_s = 1'b0;
            oe_s    = 1'b0;
            we_s    = 1'b0;
          end else begin
            addr_s  = iCpuAddr;
            dataw_s = iCpuDataW;
            write_s = iCpuWe;
            oe_s    = iCpuWe;
            we_s    = iCpuWe;
          end
        end else begin
          state_s = IDLE;
        end
      end

      ACCESS: begin
        if (cnt_r == 4'd0) begin
          state_s = DONE;
          // WE falls here while OE/address/data stay put for one hold cycle
          we_s    = 1'b0;
          if (grant_vid_r) begin
            vid_ack_s  = 1'b1;
            vid_data_s = iSramDataR;
          end else begin
            cpu_ack_s = 1'b1;
            if (!write_r) begin
              cpu_data_s = iSramDataR;
            end else begin
              cpu_data_s = cpu_data_r;
            end
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end

      DONE: begin
        state_s = IDLE;
        oe_s    = 1'b0;
        we_s    = 1'b0;
      end

      default: begin
        state_s = IDLE;
        oe_s    = 1'b0;
        we_s    = 1'b0;
      end
    endcase
  end

  // State, pin, ack and read-data registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      grant_vid_r <= 1'b0;
      write_r     <= 1'b0;
      addr_r      <= 20'd0;
      dataw_r     <= 8'd0;
      oe_r        <= 1'b0;
      we_r        <= 1'b0;
      cpu_ack_r   <= 1'b0;
      vid_ack_r   <= 1'b0;
      cpu_data_r  <= 8'd0;
      vid_data_r  <= 8'd0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      grant_vid_r <= grant_vid_s;
      write_r     <= write_s;
      addr_r      <= addr_s;
      dataw_r     <= dataw_s;
      oe_r        <= oe_s;
      we_r        <= we_s;
      cpu_ack_r   <= cpu_ack_s;
      vid_ack_r   <= vid_ack_s;
      cpu_data_r  <= cpu_data_s;
      vid_data_r  <= vid_data_s;
    end
  end

  assign oSramAddr   = addr_r;
  assign oSramDataW  = dataw_r;
  assign oSramDataOe = oe_r;
  assign oSramWe     = we_r;
  assign oCpuAck     = cpu_ack_r;
  assign oVidAck     = vid_ack_r;
  assign oCpuDataR   = cpu_data_r;
  assign oVidDataR   = vid_data_r;

endmodule
